i2c_reg_decoder: RTL and testbench
==================================

// Module: i2c_reg_decoder
// PURPOSE
//  Byte-level consumer downstream of the I2C receiver in the usbi2c bridge.
//  Takes received frames plus bus START/STOP strobes and decodes the slave transaction:
//    address byte, register pointer byte, then write data.
//  Maintains an internal 2^REG_AW x 8 register file with an auto-incrementing pointer.
//  Supplies read bytes and the ACK decision to the I2C transmit side.
// PARAMETERS
//  DEV_ADDR  7'h42  7-bit slave address this block answers to
//  REG_AW    4      register pointer width; register file depth = 2**REG_AW
// PORTS
//  sys_clk      in   1       system clock
//  rst_n        in   1       synchronous, active-low reset
//  frame_in     in   8       received byte, valid only with frame_valid
//  frame_valid  in   1       one-cycle strobe: frame_in holds a complete byte
//  bus_start    in   1       one-cycle strobe: START or repeated START detected
//  bus_stop     in   1       one-cycle strobe: STOP detected
//  ack_en       out  1       1 = ACK the current/next byte; 0 = NACK (release SDA)
//  rd_mode      out  1       1 = master-read phase active; tx side drives tx_data
//  tx_data      out  8       regs[ptr] while rd_mode
//  tx_next      in   1       one-cycle strobe from tx side: tx_data consumed
//  reg_we       out  1       one-cycle pulse: a register was written
//  reg_waddr    out  REG_AW  address of the last write
//  reg_wdata    out  8       data of the last write
//  host_raddr   in   REG_AW  host-side (USB) read address
//  host_rdata   out  8       regs[host_raddr], combinational
//  ptr_err      out  1       sticky flag; pointer byte had bits set above REG_AW
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, all regs=0, ack_en=0, rd_mode=0, reg_we=0,
//    reg_waddr=0, reg_wdata=0, ptr_err=0, tx_data=0.
//  FSM states and transitions (evaluated on sys_clk):
//   IDLE   : bus_start -> ADDR; frame_valid ignored.
//   ADDR   : on frame_valid:
//              frame_in[7:1]==DEV_ADDR && frame_in[0]==0 -> PTR, ack_en<=1.
//              frame_in[7:1]==DEV_ADDR && frame_in[0]==1 -> READ, ack_en<=1, rd_mode<=1.
//              otherwise -> IGNORE, ack_en<=0.
//   PTR    : on frame_valid: ptr<=frame_in[REG_AW-1:0]; -> WRITE.
//              If frame_in[7:REG_AW]!=0, set ptr_err (sticky until reset); still ACK.
//   WRITE  : on frame_valid: regs[ptr]<=frame_in; ptr<=ptr+1.
//              Next cycle: reg_we=1, reg_waddr=old ptr, reg_wdata=frame_in.
//   READ   : tx_data=regs[ptr] (registered, updated the cycle after ptr changes).
//              tx_next -> ptr<=ptr+1. frame_valid ignored.
//   IGNORE : everything ignored except bus_start/bus_stop.
//  Any state: bus_stop -> IDLE, ack_en<=0, rd_mode<=0; ptr retained.
//  Any state: bus_start -> ADDR, ack_en<=0, rd_mode<=0; ptr retained, so a
//    repeated-START read continues at the written pointer.
//  Simultaneous events:
//   - bus_start with frame_valid: start wins; byte dropped.
//   - bus_stop with frame_valid: byte processed (incl. write), then IDLE.
//   - bus_start with bus_stop: treat as bus_start.
//   - tx_next outside READ: ignored.
//  Pointer increments modulo 2**REG_AW (wraps 15->0 at REG_AW=4); no error on wrap.
//  Latency: frame_valid -> ack_en/state update 1 cycle; frame_valid -> reg_we 1 cycle.
//    The rx stage samples ack_en well before the 9th SCL.
//  reg_we never asserts in ADDR, PTR, READ, IGNORE or IDLE.
//  host_rdata is a read port on the same array; host read and write to the same
//    address in the same cycle returns the old value.
//  Reset mid-transaction: immediate return to reset values; regs are cleared.
// STRUCTURE
//  i2c_defs.vh (shared with i2c_rx / i2c_tx):
//    state localparams IDLE/ADDR/PTR/WRITE/READ/IGNORE (3-bit), default DEV_ADDR.
//  Sub-module i2c_regfile:
//    2**REG_AW x 8 array, one sync write port, two async read ports (ptr, host_raddr),
//    sync clear on rst_n.
//  FSM, pointer and output registers live in i2c_reg_decoder.
// TESTING
//  1. START, 0x84, 0x03, 0xAA, 0x55, STOP:
//     -> ack_en=1 after byte 1; reg_we at addr 3=0xAA and addr 4=0x55; state IDLE.
//  2. START, 0x90 (addr 0x48):
//     -> ack_en=0, IGNORE; following 0x01, 0x77 write nothing; host_rdata(1)=0.
//  3. Write 0x0F then 0x11, 0x22:
//     -> regs[15]=0x11, regs[0]=0x22 (wrap).
//     Then repeated START, 0x85, three tx_next:
//     -> tx_data 0x33 order check regs[1], regs[2], regs[3].
//  4. START, 0x84, 0x35:
//     -> ptr=5, ptr_err=1.
//     Then 0x66, STOP, 0x99 (no start):
//     -> regs[5]=0x66 only; ptr_err stays 1.
//  5. frame_valid coincident with bus_start in WRITE -> byte dropped, state ADDR.
//     frame_valid coincident with bus_stop -> byte written, state IDLE.
//  6. rst_n=0 mid-WRITE:
//     -> next cycle all outputs and regs at reset values; new START, 0x84 accepted normally.

Source files
------------

// File: rtl/i2c_reg_decoder_pkg.sv
// Shared definitions for the I2C register decoder: FSM state encoding and
// default slave address / pointer width.
package i2c_reg_decoder_pkg;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h42;
  localparam int         DEF_REG_AW   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_PTR    = 3'd2,
    ST_WRITE  = 3'd3,
    ST_READ   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_reg_decoder_if.sv
// Byte-level link between the I2C rx/tx engines (master side) and the
// register decoder (slave side).
interface i2c_reg_decoder_if;

  // Handshake: frame_valid, bus_start, bus_stop and tx_next are single-cycle
  // strobes with no ready/backpressure; the decoder must accept them on the
  // cycle they are high. ack_en, rd_mode and tx_data are level outputs.
  logic [7:0] frame_in;
  logic       frame_valid;
  logic       bus_start;
  logic       bus_stop;
  logic       tx_next;
  logic       ack_en;
  logic       rd_mode;
  logic [7:0] tx_data;

  modport master (
    output frame_in, frame_valid, bus_start, bus_stop, tx_next,
    input  ack_en, rd_mode, tx_data
  );

  modport slave (
    input  frame_in, frame_valid, bus_start, bus_stop, tx_next,
    output ack_en, rd_mode, tx_data
  );

endinterface

// File: rtl/i2c_reg_decoder_regfile.sv
// 2**AW x 8 register file: one synchronous write port, two asynchronous read
// ports, synchronous clear while rst_n is low.
module i2c_reg_decoder_regfile #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns old data.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/i2c_reg_decoder.sv
// I2C slave transaction decoder: address byte, register pointer, then write
// data into an auto-incrementing register file; serves read bytes to tx.
module i2c_reg_decoder
  import i2c_reg_decoder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         REG_AW   = DEF_REG_AW
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  i2c_reg_decoder_if.slave    bus,
  output logic                reg_we,
  output logic [REG_AW-1:0]   reg_waddr,
  output logic [7:0]          reg_wdata,
  input  logic [REG_AW-1:0]   host_raddr,
  output logic [7:0]          host_rdata,
  output logic                ptr_err,
  output state_t              dbg_state
);

  state_t            state;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        ptr_rdata;
  logic              addr_hit;
  logic              write_fire;

  assign addr_hit   = (bus.frame_in[7:1] == DEV_ADDR);
  // A START in the same cycle drops the byte, so it must not reach the array.
  assign write_fire = (state == ST_WRITE) && bus.frame_valid && !bus.bus_start;
  assign dbg_state  = state;

  i2c_reg_decoder_regfile #(.AW(REG_AW)) u_regfile (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .we      (write_fire),
    .waddr   (ptr),
    .wdata   (bus.frame_in),
    .raddr_a (ptr),
    .rdata_a (ptr_rdata),
    .raddr_b (host_raddr),
    .rdata_b (host_rdata)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      bus.ack_en  <= 1'b0;
      bus.rd_mode <= 1'b0;
      bus.tx_data <= 8'h00;
      reg_we      <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= 8'h00;
      ptr_err     <= 1'b0;
    end else begin
      reg_we      <= write_fire;
      bus.tx_data <= ptr_rdata;
      if (write_fire) begin
        reg_waddr <= ptr;
        reg_wdata <= bus.frame_in;
      end

      if (bus.bus_start) begin
        state       <= ST_ADDR;
        bus.ack_en  <= 1'b0;
        bus.rd_mode <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (bus.frame_valid) begin
            if (addr_hit && !bus.frame_in[0]) begin
              state      <= ST_PTR;
              bus.ack_en <= 1'b1;
            end else if (addr_hit) begin
              state       <= ST_READ;
              bus.ack_en  <= 1'b1;
              bus.rd_mode <= 1'b1;
            end else begin
              state      <= ST_IGNORE;
              bus.ack_en <= 1'b0;
            end
          end
          ST_PTR: if (bus.frame_valid) begin
            ptr   <= bus.frame_in[REG_AW-1:0];
            state <= ST_WRITE;
            if ((bus.frame_in >> REG_AW) != 8'h00) ptr_err <= 1'b1;
          end
          ST_WRITE: if (bus.frame_valid) ptr <= ptr + 1'b1;
          ST_READ:  if (bus.tx_next)     ptr <= ptr + 1'b1;
          default: ;
        endcase

        // STOP lands after the byte above has been processed.
        if (bus.bus_stop) begin
          state       <= ST_IDLE;
          bus.ack_en  <= 1'b0;
          bus.rd_mode <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_decoder.sv
// Directed bench for i2c_reg_decoder with a transaction-level reference model
// and a per-cycle compare process.
module tb_i2c_reg_decoder;
  import i2c_reg_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  i2c_reg_decoder_if bus ();
  logic       reg_we;
  logic [3:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic [3:0] host_raddr = 4'h0;
  logic [7:0] host_rdata;
  logic       ptr_err;
  state_t     dbg_state;

  i2c_reg_decoder #(.DEV_ADDR(7'h42), .REG_AW(4)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .ptr_err    (ptr_err),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]  m_regs [16];
  int          m_ptr;
  logic        m_ack, m_rd, m_err, m_we;
  logic [7:0]  m_tx, m_wdata;
  int          m_waddr;
  bit          in_txn, sel, rdir;
  int          nbytes;
  logic [11:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_ack = 0; m_rd = 0; m_err = 0; m_we = 0;
    m_tx = 8'h00; m_wdata = 8'h00; m_waddr = 0;
    in_txn = 0; sel = 0; rdir = 0; nbytes = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit fv, input logic [7:0] fin, input bit st,
                            input bit sp, input bit txn);
    m_tx = m_regs[m_ptr];
    m_we = 0;
    if (st) begin
      in_txn = 1; nbytes = 0; sel = 0; rdir = 0; m_ack = 0; m_rd = 0;
    end else begin
      if (in_txn && fv && !(sel && rdir)) begin
        if (nbytes == 0) begin
          sel = (fin[7:1] == 7'h42); rdir = fin[0];
          m_ack = sel; m_rd = sel && rdir;
        end else if (sel) begin
          if (nbytes == 1) begin
            m_ptr = fin % 16;
            if (fin >= 16) m_err = 1;
          end else begin
            m_regs[m_ptr] = fin;
            m_we = 1; m_waddr = m_ptr; m_wdata = fin;
            exp_q.push_back({4'(m_ptr), fin});
            m_ptr = (m_ptr + 1) % 16;
          end
        end
        nbytes++;
      end
      if (in_txn && sel && rdir && txn) m_ptr = (m_ptr + 1) % 16;
      if (sp) begin
        in_txn = 0; sel = 0; rdir = 0; m_ack = 0; m_rd = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit fv, input logic [7:0] fin, input bit st = 0,
                      input bit sp = 0, input bit txn = 0);
    @(negedge sys_clk);
    rst_n           = 1'b1;
    bus.frame_valid = fv;
    bus.frame_in    = fin;
    bus.bus_start   = st;
    bus.bus_stop    = sp;
    bus.tx_next     = txn;
    @(posedge sys_clk);
    model_step(fv, fin, st, sp, txn);
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b);
  endtask

  task automatic start();
    step(0, 8'h00, 1);
  endtask

  task automatic stop();
    step(0, 8'h00, 0, 1);
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge sys_clk);
    rst_n = 1'b1;
    bus.frame_valid = 0; bus.bus_start = 0; bus.bus_stop = 0; bus.tx_next = 0;
    host_raddr = a;
    #1;
    check(name, host_rdata, exp);
    @(posedge sys_clk);
    model_step(0, 8'h00, 0, 0, 0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    bus.frame_valid = 0; bus.bus_start = 0; bus.bus_stop = 0; bus.tx_next = 0;
    @(posedge sys_clk);
    model_reset();
    chk_en = 1'b1;
    #1;
  endtask

  // ---------------- per-cycle compare / scoreboard ----------------
  always begin
    @(posedge sys_clk);
    #2;
    if (chk_en) begin
      check("ack_en",   bus.ack_en,  m_ack);
      check("rd_mode",  bus.rd_mode, m_rd);
      check("ptr_err",  ptr_err,     m_err);
      check("reg_we",   reg_we,      m_we);
      check("reg_waddr", reg_waddr,  m_waddr);
      check("reg_wdata", reg_wdata,  m_wdata);
      check("host_rdata", host_rdata, m_regs[host_raddr]);
      if (m_rd) check("tx_data", bus.tx_data, m_tx);
      if (reg_we) begin
        if (exp_q.size() == 0) check("write_unexpected", 1, 0);
        else check("write_event", {reg_waddr, reg_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] rd_exp [3];

  initial begin
    bus.frame_in = 8'h00; bus.frame_valid = 0; bus.bus_start = 0;
    bus.bus_stop = 0; bus.tx_next = 0;
    model_reset();
    do_reset();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ack", bus.ack_en, 0);
    check("rst_tx", bus.tx_data, 8'h00);

    // 1: simple two-byte write
    start(); send(8'h84);
    check("t1_ack", bus.ack_en, 1);
    send(8'h03); send(8'hAA);
    check("t1_we0", {reg_we, reg_waddr, reg_wdata}, {1'b1, 4'h3, 8'hAA});
    send(8'h55);
    check("t1_we1", {reg_we, reg_waddr, reg_wdata}, {1'b1, 4'h4, 8'h55});
    stop();
    check("t1_state", dbg_state, ST_IDLE);
    peek(4'd3, 8'hAA, "t1_reg3");
    peek(4'd4, 8'h55, "t1_reg4");

    // 2: foreign address is ignored
    start(); send(8'h90);
    check("t2_ack", bus.ack_en, 0);
    check("t2_state", dbg_state, ST_IGNORE);
    send(8'h01); send(8'h77);
    check("t2_we", reg_we, 0);
    stop();
    peek(4'd1, 8'h00, "t2_reg1");

    // 3: pointer wrap, then repeated-START read
    start(); send(8'h84); send(8'h0F); send(8'h11); send(8'h22);
    peek(4'd15, 8'h11, "t3_reg15");
    peek(4'd0, 8'h22, "t3_reg0");
    start(); send(8'h84); send(8'h01); send(8'h33); send(8'h44); send(8'h55);
    start(); send(8'h84); send(8'h01);
    start(); send(8'h85);
    check("t3_rd_mode", bus.rd_mode, 1);
    rd_exp[0] = 8'h33; rd_exp[1] = 8'h44; rd_exp[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("t3_tx", bus.tx_data, rd_exp[i]);
      step(1, 8'hEE, 0, 0, 1);
      idle();
    end
    stop();
    check("t3_rd_off", bus.rd_mode, 0);

    // 4: out-of-range pointer, writes after STOP dropped
    start(); send(8'h84); send(8'h35);
    check("t4_err", ptr_err, 1);
    send(8'h66); stop(); send(8'h99); idle();
    check("t4_we", reg_we, 0);
    peek(4'd5, 8'h66, "t4_reg5");
    peek(4'd6, 8'h00, "t4_reg6");
    check("t4_err_sticky", ptr_err, 1);

    // 5: coincident strobes
    start(); send(8'h84); send(8'h07);
    step(1, 8'hBB, 1);
    check("t5_start_state", dbg_state, ST_ADDR);
    check("t5_start_we", reg_we, 0);
    peek(4'd7, 8'h00, "t5_reg7");
    send(8'h84); send(8'h08);
    step(1, 8'hCC, 0, 1);
    check("t5_stop_we", {reg_we, reg_waddr, reg_wdata}, {1'b1, 4'h8, 8'hCC});
    check("t5_stop_state", dbg_state, ST_IDLE);
    peek(4'd8, 8'hCC, "t5_reg8");
    step(0, 8'h00, 1, 1);
    check("t5_startstop", dbg_state, ST_ADDR);
    stop();

    // 6: reset mid-WRITE
    start(); send(8'h84); send(8'h02); send(8'hDD);
    do_reset();
    check("t6_state", dbg_state, ST_IDLE);
    check("t6_outs", {bus.ack_en, bus.rd_mode, reg_we, reg_waddr, reg_wdata, ptr_err},
          {1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0});
    check("t6_tx", bus.tx_data, 8'h00);
    peek(4'd2, 8'h00, "t6_reg2");
    peek(4'd5, 8'h00, "t6_reg5");
    start(); send(8'h84);
    check("t6_ack", bus.ack_en, 1);
    check("t6_ptr_state", dbg_state, ST_PTR);
    send(8'h00); send(8'h5A); stop();
    peek(4'd0, 8'h5A, "t6_reg0");

    idle(); idle();
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
